rx_fifo_sync: RTL

Single-clock, fully synchronous receive FIFO that buffers deserialised UART characters between the receiver and the host-side pop interface. It replaces the strobe-edge-clocked receive buffer with a clocked design. It supports simultaneous push and pop in one cycle, a programmable almost-full threshold, an exact occupancy count, and sticky overflow/underflow error flags. It also provides flush and a BIST freeze mode.

---
 rtl/rx_fifo_sync.sv | 117 +++++++++++
 1 files changed

// File: rtl/rx_fifo_sync.sv
// Single-clock receive FIFO for deserialised UART characters.
// Occupancy-counted (never pointer-compared), with sticky error flags, flush and BIST freeze.
module rx_fifo_sync #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_WIDTH = 4,
  parameter int AF_THRESH  = 2 ** (FIFO_WIDTH - 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_BITS-1:0]  Rx_Data,
  input  logic                  Data_Rdy,
  input  logic                  Pop_Data,
  input  logic                  Flush,
  input  logic                  Clear_Flags,
  input  logic                  BIST_Mode,
  output logic [DATA_BITS-1:0]  Data_Out,
  output logic                  Data_Valid,
  output logic                  FIFO_Empty,
  output logic                  FIFO_Full,
  output logic                  FIFO_Almost_Full,
  output logic                  FIFO_Overflow,
  output logic                  FIFO_Underflow,
  output logic [FIFO_WIDTH:0]   Count
);

  localparam int FIFO_ENTRIES = 2 ** FIFO_WIDTH;
  localparam logic [FIFO_WIDTH:0] ENTRIES_C = (FIFO_WIDTH + 1)'(FIFO_ENTRIES);
  localparam logic [FIFO_WIDTH:0] AF_C      = (FIFO_WIDTH + 1)'(AF_THRESH);

  logic [DATA_BITS-1:0]  mem_q [FIFO_ENTRIES];
  logic [FIFO_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_WIDTH:0]   count_q, count_d;
  logic [DATA_BITS-1:0]  data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  empty_q, empty_d, full_q, full_d, af_q, af_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic                  pop_ok, push_ok, mem_we;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a concurrent push.
  assign pop_ok  = Pop_Data && (count_q != '0);
  assign push_ok = Data_Rdy && ((count_q < ENTRIES_C) || pop_ok);

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    ovf_d        = ovf_q;
    udf_d        = udf_q;
    mem_we       = 1'b0;
    if (Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (!BIST_Mode) begin
      if (push_ok) begin
        mem_we   = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        data_out_d   = mem_q[rd_ptr_q];
        data_valid_d = 1'b1;
        rd_ptr_d     = rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
      else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
      // New error events take precedence over Clear_Flags.
      ovf_d = (ovf_q && !Clear_Flags) || (Data_Rdy && !push_ok);
      udf_d = (udf_q && !Clear_Flags) || (Pop_Data && !pop_ok);
    end
    empty_d = (count_d == '0);
    full_d  = (count_d == ENTRIES_C);
    af_d    = (count_d >= AF_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      af_q         <= 1'b0;
      ovf_q        <= 1'b0;
      udf_q        <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      af_q         <= af_d;
      ovf_q        <= ovf_d;
      udf_q        <= udf_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[wr_ptr_q] <= Rx_Data;
  end

  assign Data_Out         = data_out_q;
  assign Data_Valid       = data_valid_q;
  assign FIFO_Empty       = empty_q;
  assign FIFO_Full        = full_q;
  assign FIFO_Almost_Full = af_q;
  assign FIFO_Overflow    = ovf_q;
  assign FIFO_Underflow   = udf_q;
  assign Count            = count_q;

endmodule
